// File: rtl/seg_scan4.sv
// rtl/seg_scan4.sv - four-digit multiplexed seven-segment scan driver
//
// Ports:
//   clk    in   1  system clock, rising edge
//   reset  in   1  asynchronous active-high reset
//   Q1..Q4 in   4  digit codes, Q1 = rightmost (slot 0), Q4 = leftmost (slot 3)
//                  code 14 = minus, code 15 = blank
//   dim    in   3  brightness 0..7 (used only with SEG_DIM_EN)
//   seg    out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACT_LOW
//   an     out  4  one-hot digit enables, polarity per AN_ACT_LOW
//   frame  out  1  one-cycle pulse following each shadow capture
//
// Optional feature: define SEG_DIM_EN to build the 3-bit PWM brightness control.

module seg_scan4 #(
  parameter int DIV         = 50000,
  parameter int GAP         = 16,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit AN_ACT_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Q1,
  input  logic [3:0] Q2,
  input  logic [3:0] Q3,
  input  logic [3:0] Q4,
  input  logic [2:0] dim,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame
);

  localparam int             CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0]  GAP_CNT  = CW'(GAP);
  localparam logic [6:0]     SEG_OFF  = SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0]     AN_OFF   = AN_ACT_LOW ? 4'hF : 4'h0;

  logic [CW-1:0] cnt;
  logic [1:0]    slot;
  logic [3:0]    shadow [4];
  logic          capture;
  logic [3:0]    cur_code;
  logic [6:0]    seg_lit;
  logic          drive;

  // Capture and slot advance are mutually exclusive (cnt = 0 vs cnt = DIV-1).
  assign capture  = (cnt == '0) && (slot == 2'd0);
  assign cur_code = shadow[slot];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      slot <= 2'd0;
    end else if (cnt == CNT_LAST) begin
      cnt  <= '0;
      slot <= slot + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) shadow[i] <= 4'hF;
    end else if (capture) begin
      shadow[0] <= Q1;
      shadow[1] <= Q2;
      shadow[2] <= Q3;
      shadow[3] <= Q4;
    end
  end

  // Active-high segment pattern {g,f,e,d,c,b,a}; polarity is applied at the register.
  always_comb begin
    seg_lit = 7'h00;
    case (cur_code)
      4'd0:  seg_lit = 7'h3F;
      4'd1:  seg_lit = 7'h06;
      4'd2:  seg_lit = 7'h5B;
      4'd3:  seg_lit = 7'h4F;
      4'd4:  seg_lit = 7'h66;
      4'd5:  seg_lit = 7'h6D;
      4'd6:  seg_lit = 7'h7D;
      4'd7:  seg_lit = 7'h07;
      4'd8:  seg_lit = 7'h7F;
      4'd9:  seg_lit = 7'h6F;
      4'd10: seg_lit = 7'h77;
      4'd11: seg_lit = 7'h7C;
      4'd12: seg_lit = 7'h39;
      4'd13: seg_lit = 7'h5E;
      4'd14: seg_lit = 7'h40;
      default: seg_lit = 7'h00;
    endcase
  end

`ifdef SEG_DIM_EN
  logic [2:0] pwm;
  logic [2:0] dim_shadow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm        <= 3'd0;
      dim_shadow <= 3'd7;
    end else begin
      pwm <= pwm + 3'd1;
      if (capture) dim_shadow <= dim;
    end
  end

  // Duty is (dim+1)/8 of the open window.
  assign drive = (cnt >= GAP_CNT) && (pwm <= dim_shadow);
`else
  logic unused_dim;
  assign unused_dim = ^dim;
  assign drive      = (cnt >= GAP_CNT);
`endif

  // XOR with the off level turns an active-high pattern into the chosen polarity.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an    <= AN_OFF;
      seg   <= SEG_OFF;
      frame <= 1'b0;
    end else begin
      frame <= capture;
      if (drive) begin
        an  <= AN_OFF ^ (4'b0001 << slot);
        seg <= SEG_OFF ^ seg_lit;
      end else begin
        an  <= AN_OFF;
        seg <= SEG_OFF;
      end
    end
  end

endmodule
